// File: rtl/slice_decode_sequencer_pkg.sv
// Shared sequencer types and constants for the slice decode/encode path.
// State encoding, default timing and AC coefficient limit helper.
package slice_decode_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DC    = 3'd1,
        ST_AC    = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

    localparam int DEF_IDCT_TIME      = 12;
    localparam int DEF_AC_COEFS       = 63;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    // Product wraps silently at 32 bits; callers never see overflow.
    function automatic logic [31:0] ac_limit(
        input logic [31:0] coefs,
        input logic [31:0] blocks
    );
        return coefs * blocks;
    endfunction

endpackage

// File: rtl/slice_decode_sequencer_if.sv
// Slice control and VLD handshake bundle for the decode sequencer.
// master drives slice requests and VLD strobes; slave is the sequencer.
interface slice_decode_sequencer_if;

    logic        slice_start;
    logic [31:0] block_num;
    logic        dc_vld_valid;
    logic        ac_vld_valid;
    logic [5:0]  ac_vld_run;
    logic        slice_busy;
    logic        dc_vld_enable;
    logic [31:0] dc_vld_counter;
    logic        ac_vld_enable;
    logic [31:0] ac_vld_counter;
    logic        idct_start;
    logic        slice_done;
    logic        slice_error;

    modport master (
        output slice_start, block_num,
        output dc_vld_valid, ac_vld_valid, ac_vld_run,
        input  slice_busy, dc_vld_enable, dc_vld_counter,
        input  ac_vld_enable, ac_vld_counter,
        input  idct_start, slice_done, slice_error
    );

    modport slave (
        input  slice_start, block_num,
        input  dc_vld_valid, ac_vld_valid, ac_vld_run,
        output slice_busy, dc_vld_enable, dc_vld_counter,
        output ac_vld_enable, ac_vld_counter,
        output idct_start, slice_done, slice_error
    );

endinterface

// File: rtl/slice_decode_sequencer_watchdog.sv
// Watchdog (module slice_seq_watchdog) for DC/AC stalls.
// fire is combinational so the FSM can leave on the expiring cycle.
module slice_seq_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clock,
    input  logic reset_n,
    input  logic active,
    input  logic valid,
    output logic fire
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Count idle waiting cycles; any valid or leaving DC/AC restarts it.
    // DC->AC only happens on a valid, so state changes clear it too.
    always_comb begin
        fire  = 1'b0;
        cnt_d = 16'd0;
        if (active && !valid) begin
            if ((cnt_q + 16'd1) >= 16'(TIMEOUT_CYCLES)) begin
                fire = 1'b1;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/slice_decode_sequencer.sv
// Slice decode sequencer: DC -> AC -> IDCT drain -> done per slice.
// Optional stall watchdog enabled by defining SLICE_SEQ_TIMEOUT_EN.
module slice_decode_sequencer
    import slice_decode_sequencer_pkg::*;
#(
    parameter int IDCT_TIME      = DEF_IDCT_TIME,
    parameter int AC_COEFS       = DEF_AC_COEFS,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input logic                  clock,
    input logic                  reset_n,
    slice_decode_sequencer_if.slave bus
);

    seq_state_e  state_q, state_d;
    logic [31:0] blocks_q, blocks_d;
    logic [31:0] limit_q, limit_d;
    logic [31:0] dc_cnt_q, dc_cnt_d;
    logic [31:0] ac_cnt_q, ac_cnt_d;
    logic [15:0] drain_cnt_q, drain_cnt_d;
    logic        busy_q, busy_d;
    logic        dc_en_q, dc_en_d;
    logic        ac_en_q, ac_en_d;
    logic        idct_q, idct_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] ac_sum;
    logic        wd_fire;

`ifdef SLICE_SEQ_TIMEOUT_EN
    logic wd_active;
    logic wd_valid;

    // Watchdog watches the valid belonging to the current wait state.
    always_comb begin
        wd_active = (state_q == ST_DC) || (state_q == ST_AC);
        wd_valid  = (state_q == ST_DC) ? bus.dc_vld_valid
                                       : bus.ac_vld_valid;
    end

    slice_seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock  (clock),
        .reset_n(reset_n),
        .active (wd_active),
        .valid  (wd_valid),
        .fire   (wd_fire)
    );
`else
    logic unused_timeout;
    assign wd_fire        = 1'b0;
    assign unused_timeout = ^16'(TIMEOUT_CYCLES);
`endif

    assign ac_sum = ac_cnt_q + 32'(bus.ac_vld_run) + 32'd1;

    // Next-state, counters and registered output decode.
    always_comb begin
        state_d     = state_q;
        blocks_d    = blocks_q;
        limit_d     = limit_q;
        dc_cnt_d    = dc_cnt_q;
        ac_cnt_d    = ac_cnt_q;
        drain_cnt_d = drain_cnt_q;
        err_d       = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.slice_start) begin
                    blocks_d = bus.block_num;
                    limit_d  = ac_limit(32'(AC_COEFS), bus.block_num);
                    dc_cnt_d = 32'd0;
                    ac_cnt_d = 32'd0;
                    err_d    = 1'b0;
                    state_d  = (bus.block_num != 32'd0) ? ST_DC : ST_DONE;
                end
            end
            ST_DC: begin
                if (wd_fire) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (bus.dc_vld_valid) begin
                    dc_cnt_d = dc_cnt_q + 32'd1;
                    if (dc_cnt_q == blocks_q - 32'd1) begin
                        state_d = ST_AC;
                    end
                end
            end
            ST_AC: begin
                if (wd_fire) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (bus.ac_vld_valid) begin
                    if (ac_sum < limit_q) begin
                        ac_cnt_d = ac_sum;
                    end else if (ac_sum == limit_q) begin
                        ac_cnt_d    = ac_sum;
                        drain_cnt_d = 16'd0;
                        state_d     = ST_DRAIN;
                    end else begin
                        ac_cnt_d = limit_q;
                        err_d    = 1'b1;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == 16'(IDCT_TIME - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 16'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d  = (state_d != ST_IDLE);
        dc_en_d = (state_d == ST_DC);
        ac_en_d = (state_d == ST_AC);
        idct_d  = (state_d == ST_DRAIN) && (state_q != ST_DRAIN);
        done_d  = (state_d == ST_DONE);
    end

    // FSM state, datapath and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            blocks_q    <= 32'd0;
            limit_q     <= 32'd0;
            dc_cnt_q    <= 32'd0;
            ac_cnt_q    <= 32'd0;
            drain_cnt_q <= 16'd0;
            busy_q      <= 1'b0;
            dc_en_q     <= 1'b0;
            ac_en_q     <= 1'b0;
            idct_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            blocks_q    <= blocks_d;
            limit_q     <= limit_d;
            dc_cnt_q    <= dc_cnt_d;
            ac_cnt_q    <= ac_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            busy_q      <= busy_d;
            dc_en_q     <= dc_en_d;
            ac_en_q     <= ac_en_d;
            idct_q      <= idct_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.slice_busy     = busy_q;
    assign bus.dc_vld_enable  = dc_en_q;
    assign bus.dc_vld_counter = dc_cnt_q;
    assign bus.ac_vld_enable  = ac_en_q;
    assign bus.ac_vld_counter = ac_cnt_q;
    assign bus.idct_start     = idct_q;
    assign bus.slice_done     = done_q;
    assign bus.slice_error    = err_q;

endmodule

// File: doc/slice_decode_sequencer.md
SLICE_DECODE_SEQUENCER -- requirements
Module: slice_decode_sequencer

Interface
REQ-001 Parameter IDCT_TIME, default 12, cycles from idct_start to slice_done.
REQ-002 Parameter AC_COEFS, default 63, AC coefficients per 8x8 block.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, watchdog limit (used only when SLICE_SEQ_TIMEOUT_EN is defined).
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 slice_start  input  1  one-cycle pulse starting a slice decode.
REQ-007 block_num  input  32  blocks in slice; sampled on slice_start.
REQ-008 dc_vld_valid  input  1  DC VLD emitted one DC coefficient this cycle.
REQ-009 ac_vld_valid  input  1  AC VLD emitted one run/level pair this cycle.
REQ-010 ac_vld_run  input  6  zero-run preceding the level; coefficient position advances by run+1.
REQ-011 slice_busy  output  1  high in any state other than IDLE.
REQ-012 dc_vld_enable  output  1  high in DC state.
REQ-013 dc_vld_counter  output  32  DC coefficients accepted in current slice.
REQ-014 ac_vld_enable  output  1  high in AC state.
REQ-015 ac_vld_counter  output  32  AC coefficient positions consumed in current slice.
REQ-016 idct_start  output  1  one-cycle pulse on entry to DRAIN.
REQ-017 slice_done  output  1  one-cycle pulse in DONE.
REQ-018 slice_error  output  1  sticky error; cleared on next accepted slice_start.

Function
REQ-019 FSM states IDLE, DC, AC, DRAIN, DONE; all outputs registered.
REQ-020 IDLE: slice_start with block_num!=0 -> DC, latch block_num, clear both counters and slice_error; block_num==0 -> DONE directly, no enables.
REQ-021 slice_start outside IDLE is ignored; no restart mid-slice.
REQ-022 DC: each dc_vld_valid increments dc_vld_counter; valid when counter == block_num-1 -> AC next cycle.
REQ-023 dc_vld_valid/ac_vld_valid outside their enable state are ignored.
REQ-024 AC: on ac_vld_valid, sum = ac_vld_counter + run + 1 (32-bit); sum < AC_COEFS*block_num -> counter=sum; sum == limit -> counter=sum, -> DRAIN; sum > limit -> slice_error=1, counter saturates at limit, -> DONE.
REQ-025 Limit AC_COEFS*block_num computed once at slice_start into a 32-bit register; overflow of product is not checked.
REQ-026 DRAIN: idct_start high first cycle only; after IDCT_TIME cycles in DRAIN -> DONE.
REQ-027 DONE lasts exactly one cycle with slice_done=1, then IDLE; counters hold final values until next slice_start.
REQ-028 Latency slice_start -> dc_vld_enable high: 1 cycle.

Reset
REQ-029 On reset_n low, immediately: state IDLE, all 1-bit outputs 0, both counters 0, latched block_num and limit 0.
REQ-030 Reset mid-slice aborts with no slice_done pulse.

Configuration
REQ-031 Macro SLICE_SEQ_TIMEOUT_EN defined: 16-bit watchdog counts cycles in DC/AC without the state's valid; reaching TIMEOUT_CYCLES sets slice_error and -> DONE; cleared on each valid and on state change.
REQ-032 Macro undefined: no watchdog logic; DC/AC wait indefinitely; slice_error only from AC overrun.

Structure
REQ-033 Shared package holds state enum, default IDCT_TIME, AC_COEFS constants, shared with the encoder sequencer.
REQ-034 Watchdog is sub-module slice_seq_watchdog, instantiated only under SLICE_SEQ_TIMEOUT_EN; FSM stays in top.

Verification
REQ-035 block_num=2, two dc valids, AC runs summing to 126 positions -> idct_start once, slice_done 12 cycles later, ac_vld_counter=126, slice_error=0.
REQ-036 block_num=1, AC final pair overshoots (counter 60, run 5) -> slice_error=1, ac_vld_counter=63, slice_done next cycle, no idct_start.
REQ-037 block_num=0 -> slice_done 1 cycle after slice_start, enables never high.
REQ-038 slice_start pulsed during AC -> ignored; counters and state unchanged.
REQ-039 reset_n low during DRAIN -> all outputs 0 same cycle, no slice_done.
REQ-040 With SLICE_SEQ_TIMEOUT_EN, no dc valid for 1024 cycles -> slice_error=1, slice_done pulse.
